// File: rtl/reg2out_pkg.sv
// reg2out shared constants: default width and {p2,p1} state encoding.
// Optional feature macro: REG2OUT_BYPASS_EN (same-cycle reload on final ack).
package reg2out_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ONLY1 = 2'b01;
    localparam logic [1:0] ST_ONLY2 = 2'b10;
    localparam logic [1:0] ST_BOTH  = 2'b11;

endpackage

// File: rtl/reg2out_pend.sv
// reg2out_pend: one pending-flag cell; load overrides ack-clear.
module reg2out_pend (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic sel_bit,
    input  logic ack,
    output logic pend
);

    logic pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (load)
            pend_d = sel_bit;
        else if (ack)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pend_q <= 1'b0;
        else
            pend_q <= pend_d;
    end

    assign pend = pend_q;

endmodule

// File: rtl/reg2out.sv
// reg2out: single-entry output register forked to two acked consumers.
// Define REG2OUT_BYPASS_EN to allow a write in the cycle the last ack lands.
module reg2out
    import reg2out_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid1,
    input  logic             ack1,
    output logic             valid2,
    input  logic             ack2,
    output logic             ovf
);

    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             p1, p2;
    logic             accept;

    always_comb begin
`ifdef REG2OUT_BYPASS_EN
        in_ready = (!p1 || ack1) && (!p2 || ack2);
`else
        in_ready = !p1 && !p2;
`endif
    end

    assign accept = wen && in_ready;

    always_comb begin
        r_d   = accept ? din : r_q;
        ovf_d = ovf_q || (wen && !in_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            ovf_q <= ovf_d;
        end
    end

    reg2out_pend u_pend1 (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .sel_bit (sel[0]),
        .ack     (ack1),
        .pend    (p1)
    );

    reg2out_pend u_pend2 (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .sel_bit (sel[1]),
        .ack     (ack2),
        .pend    (p2)
    );

    assign dout   = r_q;
    assign valid1 = p1;
    assign valid2 = p2;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_reg2out.sv
// Directed self-checking bench for reg2out (both REG2OUT_BYPASS_EN builds).
module tb_reg2out;
    import reg2out_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] din = '0;
    logic [1:0]  sel = '0;
    logic        in_ready;
    logic [31:0] dout;
    logic        valid1, valid2;
    logic        ack1 = 1'b0;
    logic        ack2 = 1'b0;
    logic        ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    reg2out #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .wen      (wen),
        .din      (din),
        .sel      (sel),
        .in_ready (in_ready),
        .dout     (dout),
        .valid1   (valid1),
        .ack1     (ack1),
        .valid2   (valid2),
        .ack2     (ack2),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wen = 0; ack1 = 0; ack2 = 0;
        reset = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        reset = 0; wen = 1; din = 32'hFFFFFFFF; sel = 2'b11;
        tick();
        tick();
        total_cnt++;
        if (dout !== 32'h0) $display("FAIL rst_dout got %h exp %h", dout, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if ({valid2, valid1} !== ST_IDLE)
            $display("FAIL rst_valid got %b exp %b", {valid2, valid1}, ST_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf);
        else pass_cnt++;
        wen = 0;
        reset = 1;
        tick();
        total_cnt++;
        if (dout !== 32'h0 || valid1 !== 1'b0 || valid2 !== 1'b0)
            $display("FAIL rst_release got %h/%b%b exp 0/00", dout, valid2, valid1);
        else pass_cnt++;
    endtask

    task automatic test_fork();
        wen = 1; din = 32'h12345678; sel = 2'b11;
        tick();
        wen = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_BOTH || dout !== 32'h12345678)
            $display("FAIL fork_load got %b %h exp 11 12345678", {valid2, valid1}, dout);
        else pass_cnt++;
        tick();
        ack2 = 1;
        tick();
        ack2 = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_ONLY1 || dout !== 32'h12345678)
            $display("FAIL fork_ack2 got %b %h exp 01 12345678", {valid2, valid1}, dout);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fork_busy got %b exp 0", in_ready);
        else pass_cnt++;
        tick();
        ack1 = 1;
        tick();
        ack1 = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_IDLE || in_ready !== 1'b1)
            $display("FAIL fork_idle got %b rdy %b exp 00 1", {valid2, valid1}, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        wen = 1; din = 32'h11111111; sel = 2'b11;
        tick();
        ack1 = 1; ack2 = 1; din = 32'hA5A5A5A5;
`ifdef REG2OUT_BYPASS_EN
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", in_ready);
        else pass_cnt++;
        tick();
        wen = 0;
        total_cnt++;
        if (dout !== 32'hA5A5A5A5 || {valid2, valid1} !== ST_BOTH || ovf !== 1'b0)
            $display("FAIL b2b_load got %h %b ovf %b exp a5a5a5a5 11 0",
                     dout, {valid2, valid1}, ovf);
        else pass_cnt++;
`else
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_ready got %b exp 0", in_ready);
        else pass_cnt++;
        tick();
        ack1 = 0; ack2 = 0;
        total_cnt++;
        if (dout !== 32'h11111111 || {valid2, valid1} !== ST_IDLE || ovf !== 1'b1)
            $display("FAIL b2b_bubble got %h %b ovf %b exp 11111111 00 1",
                     dout, {valid2, valid1}, ovf);
        else pass_cnt++;
        tick();
        wen = 0;
        total_cnt++;
        if (dout !== 32'hA5A5A5A5 || {valid2, valid1} !== ST_BOTH)
            $display("FAIL b2b_load got %h %b exp a5a5a5a5 11", dout, {valid2, valid1});
        else pass_cnt++;
        ack1 = 1; ack2 = 1;
`endif
        tick();
        ack1 = 0; ack2 = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_IDLE)
            $display("FAIL b2b_drain got %b exp 00", {valid2, valid1});
        else pass_cnt++;
    endtask

    task automatic test_masked();
        wen = 1; din = 32'h0000BEEF; sel = 2'b10;
        tick();
        wen = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_ONLY2 || dout !== 32'h0000BEEF)
            $display("FAIL mask_load got %b %h exp 10 0000beef", {valid2, valid1}, dout);
        else pass_cnt++;
        ack1 = 1;
        tick();
        ack1 = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_ONLY2)
            $display("FAIL mask_stray got %b exp 10", {valid2, valid1});
        else pass_cnt++;
        ack2 = 1;
        tick();
        ack2 = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_IDLE || in_ready !== 1'b1)
            $display("FAIL mask_done got %b rdy %b exp 00 1", {valid2, valid1}, in_ready);
        else pass_cnt++;
        wen = 1; din = 32'hCAFE0001; sel = 2'b00;
        tick();
        wen = 0;
        total_cnt++;
        if (dout !== 32'hCAFE0001 || {valid2, valid1} !== ST_IDLE || in_ready !== 1'b1)
            $display("FAIL mask_none got %h %b rdy %b exp cafe0001 00 1",
                     dout, {valid2, valid1}, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        wen = 1; din = 32'h0BADF00D; sel = 2'b11;
        tick();
        din = 32'hDEADBEEF;
        tick();
        wen = 0;
        total_cnt++;
        if (dout !== 32'h0BADF00D || ovf !== 1'b1 || {valid2, valid1} !== ST_BOTH)
            $display("FAIL ovf_reject got %h ovf %b st %b exp 0badf00d 1 11",
                     dout, ovf, {valid2, valid1});
        else pass_cnt++;
        ack1 = 1; ack2 = 1;
        tick();
        ack1 = 0; ack2 = 0;
        tick();
        total_cnt++;
        if (ovf !== 1'b1 || {valid2, valid1} !== ST_IDLE)
            $display("FAIL ovf_sticky got ovf %b st %b exp 1 00", ovf, {valid2, valid1});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wen = 1; din = 32'h00000077; sel = 2'b01;
        tick();
        wen = 0;
        total_cnt++;
        if ({valid2, valid1} !== ST_ONLY1 || dout !== 32'h77)
            $display("FAIL mid_load got %b %h exp 01 00000077", {valid2, valid1}, dout);
        else pass_cnt++;
        #2;
        reset = 0;
        #1;
        total_cnt++;
        if (valid1 !== 1'b0 || dout !== 32'h0 || in_ready !== 1'b1 || ovf !== 1'b0)
            $display("FAIL mid_async got v1 %b %h rdy %b ovf %b exp 0 0 1 0",
                     valid1, dout, in_ready, ovf);
        else pass_cnt++;
        reset = 1;
        tick();
        total_cnt++;
        if ({valid2, valid1} !== ST_IDLE || dout !== 32'h0)
            $display("FAIL mid_after got %b %h exp 00 0", {valid2, valid1}, dout);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fork();
        test_back_to_back();
        test_masked();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg2out.md
# reg2out

Single-entry output register that forks one written value to two independent consumers, each with its own valid/ack handshake. It is the read-side counterpart to the two-writer input register in the cpu2 datapath. A value is loaded once and held stable until every selected consumer has acknowledged it, and only then is the next write accepted. Used where one result (e.g. ALU output) must be consumed by two units that may take it in different cycles.

## Interface
Parameters:
- WIDTH, 32, data width in bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; all state is cleared while low
- wen  input  1  write request from producer
- din  input  WIDTH  write data
- sel  input  2  consumer mask sampled with the write; bit0 = consumer 1, bit1 = consumer 2
- in_ready  output  1  producer may write this cycle
- dout  output  WIDTH  held data, common to both consumers
- valid1  output  1  dout pending for consumer 1
- ack1  input  1  consumer 1 takes dout
- valid2  output  1  dout pending for consumer 2
- ack2  input  1  consumer 2 takes dout
- ovf  output  1  sticky flag: a write was attempted while not ready

## Operation
- State: data register r[WIDTH-1:0] and pending flags p1, p2. Encoded FSM view: IDLE (p1=0,p2=0), BOTH (1,1), ONLY1 (1,0), ONLY2 (0,1).
- Reset values: r=0, p1=p2=0, ovf=0; hence dout=0, valid1=valid2=0, in_ready=1.
- valid1=p1, valid2=p2, dout=r.
- Accept: wen && in_ready -> r<=din; p1<=sel[0]; p2<=sel[1]. sel=2'b00 updates r and leaves state IDLE.
- Consume: ack_i && p_i clears p_i at the next edge. ack_i while p_i=0 is ignored.
- Transitions: BOTH -ack1-> ONLY2, BOTH -ack2-> ONLY1, BOTH -ack1&ack2-> IDLE; ONLY1 -ack1-> IDLE; ONLY2 -ack2-> IDLE; IDLE -accept-> state given by sel.
- Rejected write: wen && !in_ready -> r and flags unchanged, ovf<=1. ovf clears only on reset.
- Reset asserted mid-transaction: pending data is discarded, outputs return to reset values immediately (asynchronous).

## Timing
- Write accepted at edge N -> dout/valid_i visible after edge N (latency 1).
- dout is stable for the whole interval during which either valid is high.
- in_ready is a function of state (and, with bypass, of ack inputs); it never depends on wen.
- Consumers may ack in the same cycle or in any order; each consumer sees exactly one valid pulse-train per accepted write.

## Configuration
- REG2OUT_BYPASS_EN defined: in_ready = (p1 ? ack1 : 1) && (p2 ? ack2 : 1). A new write may be accepted in the same cycle that the last pending ack clears the entry; the flags load from sel (load overrides clear). Throughput is 1 write/cycle when consumers ack immediately. in_ready is combinational from ack1/ack2.
- Not defined: in_ready = !p1 && !p2 (registered-state only). At least one bubble cycle between final ack and the next accept; maximum throughput is 1 write per 2 cycles.

## Structure
- Package reg2out_pkg: WIDTH default constant, state encoding localparams (ST_IDLE, ST_BOTH, ST_ONLY1, ST_ONLY2) for use by the bench and by assertions.
- One sub-module, reg2out_pend: a single pending-flag cell (set on load with its sel bit, clear on ack, async active-low reset), instantiated twice. Data register and ovf remain in the top level.

## Test plan
- Reset: hold reset low with wen=1, din=32'hFFFFFFFF -> dout=0, valid1=valid2=0, in_ready=1, ovf=0; release and check that nothing is loaded before the first enabled edge.
- Fork, ordered acks: write din=32'h12345678 with sel=2'b11 -> both valids high next cycle; ack2 at cycle 3 -> valid2=0, valid1=1, dout unchanged; ack1 at cycle 5 -> IDLE, in_ready=1.
- Simultaneous acks plus back-to-back writes: ack1=ack2=1 on the first valid cycle while wen=1, din=32'hA5A5A5A5 -> with REG2OUT_BYPASS_EN the new value loads on that edge; without it it is not loaded, ovf=1, and the write is accepted one cycle later.
- Masked write: sel=2'b10, din=32'h0000BEEF -> valid2=1 only, valid1 stays 0; stray ack1 is ignored; ack2 returns state to IDLE. sel=2'b00 -> dout updates, both valids stay 0.
- Overflow: in BOTH, wen=1 with din=32'hDEADBEEF -> dout keeps the old value, ovf=1 and remains 1 after both acks until reset.
- Reset mid-transaction: in ONLY1, pulse reset low for less than one cycle (asynchronous) -> valid1 drops immediately, dout=0, in_ready=1.
